// File: rtl/la_sram_bus_master.sv
// rtl/la_sram_bus_master.sv - OpenLA500 inst/data SRAM channels to single-outstanding a/d/we/rd bus
// Data requests win arbitration; partial-word stores become a read-modify-write pair of bus cycles.
module la_sram_bus_master #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [31:0] a,
  output logic [31:0] d,
  output logic        we,
  output logic        rd,
  input  logic [31:0] spo,
  input  logic        ready
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_a;
  logic [31:0] r_d;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;
  logic        r_src_data;
  logic        r_write;
  logic        r_rmw;
  logic        r_empty;

  logic        w_idle;
  logic        w_take_data;
  logic        w_take_inst;
  logic        w_on_bus;
  logic        w_full_store;
  logic        w_part_store;
  logic        w_empty_store;
  logic [31:0] w_merged;
  logic        w_unused;

  assign w_idle        = (r_state == S_IDLE);
  assign w_take_data   = w_idle && data_req;
  assign w_take_inst   = w_idle && inst_req && !data_req;
  assign w_full_store  = data_wr && (data_wstrb == 4'hF);
  assign w_empty_store = data_wr && (data_wstrb == 4'h0);
  assign w_part_store  = data_wr && !w_full_store && !w_empty_store;

  assign data_addr_ok = rst_n && w_take_data;
  assign inst_addr_ok = rst_n && w_take_inst;

  // An empty store spends its REQ cycle without a strobe, so the core sees no bus access.
  assign w_on_bus = (r_state == S_REQ) || (r_state == S_WAIT);
  assign rd       = w_on_bus && !r_write && !r_empty;
  assign we       = w_on_bus && r_write;
  assign a        = r_a;
  assign d        = r_d;

  assign inst_data_ok = (r_state == S_RESP) && !r_src_data;
  assign data_data_ok = (r_state == S_RESP) && r_src_data;
  assign inst_rdata   = r_inst_rdata;
  assign data_rdata   = r_data_rdata;

  assign w_unused = ^{inst_addr[1:0], data_addr[1:0]};

  always_comb begin
    w_merged = spo;
    for (int i = 0; i < 4; i++) begin
      if (r_wstrb[i]) begin
        w_merged[8*i +: 8] = r_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= RESET_ADDR;
      r_d          <= 32'h0;
      r_wdata      <= 32'h0;
      r_wstrb      <= 4'h0;
      r_inst_rdata <= 32'h0;
      r_data_rdata <= 32'h0;
      r_src_data   <= 1'b0;
      r_write      <= 1'b0;
      r_rmw        <= 1'b0;
      r_empty      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take_data || w_take_inst) begin
            r_a        <= w_take_data ? {data_addr[31:2], 2'b00} : {inst_addr[31:2], 2'b00};
            r_src_data <= w_take_data;
            r_wdata    <= data_wdata;
            r_wstrb    <= data_wstrb;
            r_write    <= w_take_data && w_full_store;
            r_rmw      <= w_take_data && w_part_store;
            r_empty    <= w_take_data && w_empty_store;
            if (w_take_data && w_full_store) begin
              r_d <= data_wdata;
            end
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_state <= r_empty ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (ready) begin
            if (r_write) begin
              r_state <= S_RESP;
            end else if (r_rmw) begin
              // Read phase done: merged word goes out on the following write phase.
              r_d     <= w_merged;
              r_write <= 1'b1;
              r_state <= S_REQ;
            end else begin
              if (r_src_data) begin
                r_data_rdata <= spo;
              end else begin
                r_inst_rdata <= spo;
              end
              r_state <= S_RESP;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_la_sram_bus_master.sv
// tb/tb_la_sram_bus_master.sv - directed bench for la_sram_bus_master with per-cycle reference model
// The model tracks each accepted request as a queue of pending bus operations.
module tb_la_sram_bus_master;
  localparam logic [31:0] RST_A = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        ready;

  int n_tests = 0;
  int n_fail  = 0;
  int slave_wait = 0;

  logic [31:0] mem [logic [31:0]];

  la_sram_bus_master #(.RESET_ADDR(RST_A)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion", nm);
  endtask

  // Slave: ready rises after slave_wait strobe cycles counted from the REQ cycle.
  initial begin
    int cnt;
    logic [1:0] prev;
    cnt = 0; prev = 2'b00; ready = 1'b0; spo = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!(rd || we)) cnt = 0;
      else if ({rd, we} != prev) cnt = 1;
      else cnt++;
      prev  = {rd, we};
      ready = (rd || we) && (cnt > slave_wait);
      spo   = mem.exists(a) ? mem[a] : 32'h0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && we && ready) mem[a] = d;
    end
  end

  typedef struct {
    int          kind;    // 0 no bus access, 1 read, 2 write
    bit          merge;
    logic [31:0] data;
  } op_t;

  op_t         m_ops[$];
  bit          m_busy, m_first, m_resp, m_src;
  logic [31:0] m_a, m_d, m_irdata, m_drdata, m_wdata, m_mask;

  initial begin
    logic e_rd, e_we;
    op_t  op;
    m_busy = 0; m_first = 0; m_resp = 0; m_src = 0;
    m_a = RST_A; m_d = 0; m_irdata = 0; m_drdata = 0; m_wdata = 0; m_mask = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ops.delete();
        m_busy = 0; m_first = 0; m_resp = 0;
        m_a = RST_A; m_d = 0; m_irdata = 0; m_drdata = 0;
      end
      e_rd = m_busy && !m_resp && (m_ops.size() > 0) && (m_ops[0].kind == 1);
      e_we = m_busy && !m_resp && (m_ops.size() > 0) && (m_ops[0].kind == 2);
      chk("cyc rd", rd, e_rd);
      chk("cyc we", we, e_we);
      chk("cyc a", a, m_a);
      chk("cyc d", d, m_d);
      chk("cyc data_addr_ok", data_addr_ok, rst_n && !m_busy && data_req);
      chk("cyc inst_addr_ok", inst_addr_ok, rst_n && !m_busy && inst_req && !data_req);
      chk("cyc inst_data_ok", inst_data_ok, m_resp && !m_src);
      chk("cyc data_data_ok", data_data_ok, m_resp && m_src);
      chk("cyc inst_rdata", inst_rdata, m_irdata);
      chk("cyc data_rdata", data_rdata, m_drdata);
      if (rst_n) begin
        if (m_resp) begin
          m_resp = 0;
          m_busy = 0;
        end else if (m_busy) begin
          if (m_ops[0].kind == 0) begin
            void'(m_ops.pop_front());
            m_resp = 1;
          end else if (m_first) begin
            m_first = 0;
          end else if (ready) begin
            op = m_ops.pop_front();
            if (op.kind == 1 && op.merge) m_d = (spo & ~m_mask) | (m_wdata & m_mask);
            else if (op.kind == 1 && m_src) m_drdata = spo;
            else if (op.kind == 1) m_irdata = spo;
            if (m_ops.size() == 0) m_resp = 1;
            else m_first = 1;
          end
        end else if (data_req || inst_req) begin
          m_busy  = 1;
          m_first = 1;
          m_src   = data_req;
          m_a     = data_req ? {data_addr[31:2], 2'b00} : {inst_addr[31:2], 2'b00};
          m_wdata = data_wdata;
          m_mask  = {{8{data_wstrb[3]}}, {8{data_wstrb[2]}}, {8{data_wstrb[1]}}, {8{data_wstrb[0]}}};
          if (!data_req || !data_wr) begin
            m_ops.push_back('{kind: 1, merge: 0, data: 32'h0});
          end else if (data_wstrb == 4'hF) begin
            m_ops.push_back('{kind: 2, merge: 0, data: data_wdata});
            m_d = data_wdata;
          end else if (data_wstrb == 4'h0) begin
            m_ops.push_back('{kind: 0, merge: 0, data: 32'h0});
          end else begin
            m_ops.push_back('{kind: 1, merge: 1, data: 32'h0});
            m_ops.push_back('{kind: 2, merge: 0, data: 32'h0});
          end
        end
      end
    end
  end

  task automatic run_txn(input bit is_data, input bit wr, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int nrd, output int nwe,
                         output int noki, output int nokd,
                         output logic [31:0] d_we, output logic [31:0] a_bus);
    int acc, okc;
    acc = -1; okc = -1; lat = -1; nrd = 0; nwe = 0; noki = 0; nokd = 0;
    d_we = 32'h0; a_bus = 32'h0;
    @(posedge clk); #1;
    if (is_data) begin
      data_req = 1'b1; data_wr = wr; data_wstrb = strb; data_addr = addr; data_wdata = wdata;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (rd) nrd++;
      if (we) begin nwe++; d_we = d; end
      if (rd || we) a_bus = a;
      if (acc >= 0) begin
        noki += int'(inst_data_ok);
        nokd += int'(data_data_ok);
      end
      if (okc < 0 && acc >= 0 && (is_data ? data_data_ok : inst_data_ok)) begin
        okc = k;
        lat = k - acc;
      end
      if (okc >= 0 && k >= okc + 2) break;
      if (acc < 0 && (is_data ? data_addr_ok : inst_addr_ok)) begin
        acc = k;
        @(posedge clk); #1;
        inst_req = 1'b0; data_req = 1'b0;
      end else if (acc < 0 && k >= 20) begin
        break;
      end
    end
    inst_req = 1'b0; data_req = 1'b0;
    if (acc < 0) fail_now("addr_ok wait");
    else if (okc < 0) fail_now("data_ok wait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nrd, nwe, noki, nokd, dk, ik, dok, iok, last_s, first_s, cnt_ok;
    logic [31:0] d_we, a_bus;
    mem[32'h0000_1004] = 32'hDEAD_BEEF;
    mem[32'h0000_1008] = 32'hCAFE_F00D;
    mem[32'h2000_0020] = 32'hAABB_CCDD;
    rst_n = 1'b0; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wr = 1'b0;
    data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("reset a", a, RST_A);
    chk("reset d", d, 32'h0);
    chk("reset strobes", {30'h0, rd, we}, 32'h0);
    chk("reset rdata", inst_rdata | data_rdata, 32'h0);

    slave_wait = 0;
    run_txn(0, 0, 4'h0, 32'h0000_1006, 32'h0, lat, nrd, nwe, noki, nokd, d_we, a_bus);
    chk("fetch latency", lat, 3);
    chk("fetch rd cycles", nrd, 2);
    chk("fetch we cycles", nwe, 0);
    chk("fetch a", a_bus, 32'h0000_1004);
    chk("fetch inst_rdata", inst_rdata, 32'hDEAD_BEEF);
    chk("fetch inst_data_ok count", noki, 1);
    chk("fetch data_data_ok count", nokd, 0);

    slave_wait = 3;
    run_txn(1, 1, 4'hF, 32'h1000_0010, 32'h1234_5678, lat, nrd, nwe, noki, nokd, d_we, a_bus);
    chk("full store we cycles", nwe, 4);
    chk("full store rd cycles", nrd, 0);
    chk("full store d", d_we, 32'h1234_5678);
    chk("full store data_ok count", nokd, 1);
    chk("full store latency", lat, 5);
    chk("full store mem", mem[32'h1000_0010], 32'h1234_5678);

    slave_wait = 0;
    run_txn(1, 0, 4'h0, 32'h1000_0012, 32'h0, lat, nrd, nwe, noki, nokd, d_we, a_bus);
    chk("load latency", lat, 3);
    chk("load data_rdata", data_rdata, 32'h1234_5678);

    run_txn(1, 1, 4'b0101, 32'h2000_0021, 32'h1122_3344, lat, nrd, nwe, noki, nokd, d_we, a_bus);
    chk("partial latency", lat, 5);
    chk("partial rd cycles", nrd, 2);
    chk("partial we cycles", nwe, 2);
    chk("partial d", d_we, 32'hAA22_CC44);
    chk("partial mem", mem[32'h2000_0020], 32'hAA22_CC44);

    run_txn(1, 1, 4'h0, 32'h3000_0000, 32'hFFFF_FFFF, lat, nrd, nwe, noki, nokd, d_we, a_bus);
    chk("empty store latency", lat, 2);
    chk("empty store strobes", nrd + nwe, 0);
    chk("empty store data_ok count", nokd, 1);

    // Contention: both channels request in the same idle cycle.
    dk = -1; ik = -1; dok = -1; iok = -1; last_s = -1; first_s = -1;
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h0000_1008;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1000_0010;
    for (int k = 0; k < 40; k++) begin
      bit drop_d, drop_i;
      @(negedge clk);
      drop_d = 0; drop_i = 0;
      if (dk < 0 && data_addr_ok) begin dk = k; drop_d = 1; end
      if (ik < 0 && inst_addr_ok) begin ik = k; drop_i = 1; end
      if (dok < 0 && data_data_ok) dok = k;
      if (iok < 0 && inst_data_ok) iok = k;
      if ((rd || we) && ik < 0) last_s = k;
      if ((rd || we) && ik >= 0 && first_s < 0) first_s = k;
      if (iok >= 0) break;
      if (drop_d || drop_i) begin
        @(posedge clk); #1;
        if (drop_d) data_req = 1'b0;
        if (drop_i) inst_req = 1'b0;
      end
    end
    inst_req = 1'b0; data_req = 1'b0;
    if (iok < 0 || dk < 0) fail_now("contention wait");
    else begin
      chk("contention data first", dk < ik, 1);
      chk("contention data served first", dok < iok, 1);
      chk("contention inst accept after resp", ik, dok + 1);
      chk("contention bus gap", (first_s - last_s - 1) >= 1, 1);
      chk("contention inst_rdata", inst_rdata, 32'hCAFE_F00D);
      chk("contention data_rdata", data_rdata, 32'h1234_5678);
    end

    // Reset while a fetch is stalled in WAIT.
    slave_wait = 30;
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h0000_1004;
    ik = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (inst_addr_ok) begin ik = k; break; end
    end
    if (ik < 0) fail_now("reset test accept");
    @(posedge clk); #1;
    inst_req = 1'b0;
    @(posedge clk); #3;
    chk("pre-reset rd", rd, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset rd drop", rd, 1'b0);
    chk("reset we", we, 1'b0);
    chk("reset a mid", a, RST_A);
    chk("reset inst_rdata mid", inst_rdata, 32'hCAFE_F00D & 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    slave_wait = 0;
    cnt_ok = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cnt_ok += int'(inst_data_ok) + int'(data_data_ok);
    end
    chk("no data_ok after reset", cnt_ok, 0);
    run_txn(0, 0, 4'h0, 32'h0000_1004, 32'h0, lat, nrd, nwe, noki, nokd, d_we, a_bus);
    chk("post-reset fetch latency", lat, 3);
    chk("post-reset fetch rdata", inst_rdata, 32'hDEAD_BEEF);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
